// File: rtl/gelato_multi_warp_fetch.sv
// ---------------------------------------------------------------------------
// gelato_multi_warp_fetch
//
// Multi-warp instruction fetch stage. Keeps a PC, an active bit and an
// ibuffer credit count for every warp. Warps are picked round-robin. The
// chosen warp issues one bundle-aligned request to the L1 instruction cache,
// and the returned bundle goes to decode/ibuffer with a mask of valid slots.
// Only one request is outstanding at a time. A redirect or finish aimed at
// the in-flight warp marks the outstanding response stale, so it is dropped
// when it returns.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   rdy                          global enable; low freezes every register
//   init_*                       start an inactive warp at init_pc
//   redirect_*                   replace the PC of an active warp
//   finish_*                     deactivate a warp
//   credit_*                     ibuffer freed one bundle slot of a warp
//   req_valid/req_ready/req_addr cache request handshake (aligned address)
//   resp_valid/resp_data         in-order cache response, slot 0 in LSBs
//   out_*                        one-cycle bundle to decode with slot mask
//   active_mask                  current active bit of every warp
// ---------------------------------------------------------------------------
module gelato_multi_warp_fetch #(
  parameter  int NUM_WARPS   = 8,
  parameter  int PC_WIDTH    = 32,
  parameter  int INST_WIDTH  = 32,
  parameter  int FETCH_WIDTH = 2,
  parameter  int IBUF_DEPTH  = 4,
  localparam int WARP_ID_W   = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int SLOT_W      = $clog2(FETCH_WIDTH)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              rdy,
  input  logic                              init_valid,
  input  logic [WARP_ID_W-1:0]              init_warp_id,
  input  logic [PC_WIDTH-1:0]               init_pc,
  input  logic                              redirect_valid,
  input  logic [WARP_ID_W-1:0]              redirect_warp_id,
  input  logic [PC_WIDTH-1:0]               redirect_pc,
  input  logic                              finish_valid,
  input  logic [WARP_ID_W-1:0]              finish_warp_id,
  input  logic                              credit_valid,
  input  logic [WARP_ID_W-1:0]              credit_warp_id,
  output logic                              req_valid,
  input  logic                              req_ready,
  output logic [PC_WIDTH-1:0]               req_addr,
  input  logic                              resp_valid,
  input  logic [FETCH_WIDTH*INST_WIDTH-1:0] resp_data,
  output logic                              out_valid,
  output logic [WARP_ID_W-1:0]              out_warp_id,
  output logic [PC_WIDTH-1:0]               out_pc,
  output logic [FETCH_WIDTH*INST_WIDTH-1:0] out_data,
  output logic [FETCH_WIDTH-1:0]            out_mask,
  output logic [NUM_WARPS-1:0]              active_mask
);

  localparam int SLOT_IDX_W   = (SLOT_W > 0) ? SLOT_W : 1;
  localparam int CRED_W       = $clog2(IBUF_DEPTH + 1);
  localparam int BUNDLE_BYTES = FETCH_WIDTH * 4;
  localparam int DATA_W       = FETCH_WIDTH * INST_WIDTH;
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(BUNDLE_BYTES - 1);
  localparam logic [PC_WIDTH-1:0] SLOT_MASK  = PC_WIDTH'(FETCH_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT
  } state_e;

  state_e                  state_q, state_d;
  logic [WARP_ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [WARP_ID_W-1:0]    cur_warp_q, cur_warp_d;
  logic [SLOT_IDX_W-1:0]   slot_q, slot_d;
  logic                    stale_q, stale_d;
  logic                    req_valid_q, req_valid_d;
  logic [PC_WIDTH-1:0]     req_addr_q, req_addr_d;
  logic                    out_valid_q, out_valid_d;
  logic [WARP_ID_W-1:0]    out_warp_id_q, out_warp_id_d;
  logic [PC_WIDTH-1:0]     out_pc_q, out_pc_d;
  logic [DATA_W-1:0]       out_data_q, out_data_d;
  logic [FETCH_WIDTH-1:0]  out_mask_q, out_mask_d;
  logic [NUM_WARPS-1:0]    active_q, active_d;
  logic [PC_WIDTH-1:0]     pc_q [NUM_WARPS];
  logic [PC_WIDTH-1:0]     pc_d [NUM_WARPS];
  logic [CRED_W-1:0]       credits_q [NUM_WARPS];
  logic [CRED_W-1:0]       credits_d [NUM_WARPS];

  logic                    pick_found;
  logic [WARP_ID_W-1:0]    pick_id;
  logic [WARP_ID_W-1:0]    pick_cand;
  logic                    do_pick;
  logic                    flight_valid;
  logic [WARP_ID_W-1:0]    flight_id;
  logic                    flight_redirect;
  logic                    flight_finish;
  logic                    restore_credit;
  logic                    advance_pc;
  logic [FETCH_WIDTH-1:0]  slot_mask;
  int                      cred_sum;

  // Round-robin search starting one past the last granted warp. A warp with
  // no credits has no room in its ibuffer and is skipped.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    pick_cand  = '0;
    for (int i = 1; i <= NUM_WARPS; i++) begin
      pick_cand = WARP_ID_W'((int'(rr_ptr_q) + i) % NUM_WARPS);
      if (!pick_found && active_q[pick_cand] && (credits_q[pick_cand] != '0)) begin
        pick_found = 1'b1;
        pick_id    = pick_cand;
      end
    end
  end

  // The warp picked this cycle is treated as in flight already. A redirect
  // or finish that lands on the grant cycle must still squash the request,
  // because that request was built from the old PC.
  always_comb begin
    do_pick         = (state_q == ST_IDLE) && pick_found;
    flight_valid    = (state_q != ST_IDLE) || do_pick;
    flight_id       = (state_q == ST_IDLE) ? pick_id : cur_warp_q;
    flight_redirect = flight_valid && redirect_valid &&
                      (redirect_warp_id == flight_id) && active_q[flight_id];
    flight_finish   = flight_valid && finish_valid && (finish_warp_id == flight_id);
  end

  // Slots below the entry PC's offset within the bundle are not part of the
  // instruction stream and are masked off.
  always_comb begin
    slot_mask = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      slot_mask[i] = (i >= int'(slot_q));
    end
  end

  // Fetch FSM and per-warp table next-state logic.
  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    cur_warp_d     = cur_warp_q;
    slot_d         = slot_q;
    stale_d        = stale_q;
    req_valid_d    = req_valid_q;
    req_addr_d     = req_addr_q;
    out_valid_d    = 1'b0;
    out_warp_id_d  = out_warp_id_q;
    out_pc_d       = out_pc_q;
    out_data_d     = out_data_q;
    out_mask_d     = out_mask_q;
    active_d       = active_q;
    restore_credit = 1'b0;
    advance_pc     = 1'b0;
    cred_sum       = 0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      pc_d[w]      = pc_q[w];
      credits_d[w] = credits_q[w];
    end

    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d     = ST_REQ;
          cur_warp_d  = pick_id;
          rr_ptr_d    = pick_id;
          req_valid_d = 1'b1;
          req_addr_d  = pc_q[pick_id] & ALIGN_MASK;
          slot_d      = SLOT_IDX_W'((pc_q[pick_id] >> 2) & SLOT_MASK);
          stale_d     = flight_redirect || flight_finish;
        end
      end
      ST_REQ: begin
        if (req_ready) begin
          state_d     = ST_WAIT;
          req_valid_d = 1'b0;
        end
        if (flight_redirect || flight_finish) begin
          stale_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (resp_valid) begin
          state_d = ST_IDLE;
          stale_d = 1'b0;
          if (stale_q || flight_redirect || flight_finish) begin
            restore_credit = 1'b1;
          end else begin
            out_valid_d   = 1'b1;
            out_warp_id_d = cur_warp_q;
            out_pc_d      = req_addr_q;
            out_data_d    = resp_data;
            out_mask_d    = slot_mask;
            advance_pc    = 1'b1;
          end
        end else if (flight_redirect || flight_finish) begin
          stale_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Per-warp updates. Credit return, consume and squash refund are summed
    // so simultaneous return and consume cancel. Redirect overrides the
    // sequential advance, and finish overrides init on the same warp.
    for (int w = 0; w < NUM_WARPS; w++) begin
      cred_sum = int'(credits_q[w])
               + ((credit_valid && (credit_warp_id == WARP_ID_W'(w))) ? 1 : 0)
               + ((restore_credit && (cur_warp_q == WARP_ID_W'(w))) ? 1 : 0)
               - ((do_pick && (pick_id == WARP_ID_W'(w))) ? 1 : 0);
      if (cred_sum > IBUF_DEPTH) begin
        cred_sum = IBUF_DEPTH;
      end
      credits_d[w] = CRED_W'(cred_sum);

      if (advance_pc && (cur_warp_q == WARP_ID_W'(w))) begin
        pc_d[w] = req_addr_q + PC_WIDTH'(BUNDLE_BYTES);
      end
      if (redirect_valid && (redirect_warp_id == WARP_ID_W'(w)) && active_q[w]) begin
        pc_d[w] = redirect_pc;
      end
      if (init_valid && (init_warp_id == WARP_ID_W'(w)) && !active_q[w] &&
          !(finish_valid && (finish_warp_id == WARP_ID_W'(w)))) begin
        active_d[w]  = 1'b1;
        pc_d[w]      = init_pc;
        credits_d[w] = CRED_W'(IBUF_DEPTH);
      end
      if (finish_valid && (finish_warp_id == WARP_ID_W'(w))) begin
        active_d[w] = 1'b0;
      end
    end
  end

  // State registers. Reset drops any outstanding request and restores full
  // credits. With rdy low, everything holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= '0;
      cur_warp_q    <= '0;
      slot_q        <= '0;
      stale_q       <= 1'b0;
      req_valid_q   <= 1'b0;
      req_addr_q    <= '0;
      out_valid_q   <= 1'b0;
      out_warp_id_q <= '0;
      out_pc_q      <= '0;
      out_data_q    <= '0;
      out_mask_q    <= '0;
      active_q      <= '0;
      for (int w = 0; w < NUM_WARPS; w++) begin
        pc_q[w]      <= '0;
        credits_q[w] <= CRED_W'(IBUF_DEPTH);
      end
    end else if (rdy) begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      cur_warp_q    <= cur_warp_d;
      slot_q        <= slot_d;
      stale_q       <= stale_d;
      req_valid_q   <= req_valid_d;
      req_addr_q    <= req_addr_d;
      out_valid_q   <= out_valid_d;
      out_warp_id_q <= out_warp_id_d;
      out_pc_q      <= out_pc_d;
      out_data_q    <= out_data_d;
      out_mask_q    <= out_mask_d;
      active_q      <= active_d;
      for (int w = 0; w < NUM_WARPS; w++) begin
        pc_q[w]      <= pc_d[w];
        credits_q[w] <= credits_d[w];
      end
    end
  end

  assign req_valid   = req_valid_q;
  assign req_addr    = req_addr_q;
  assign out_valid   = out_valid_q;
  assign out_warp_id = out_warp_id_q;
  assign out_pc      = out_pc_q;
  assign out_data    = out_data_q;
  assign out_mask    = out_mask_q;
  assign active_mask = active_q;

endmodule

// File: tb/tb_gelato_multi_warp_fetch.sv
// ---------------------------------------------------------------------------
// tb_gelato_multi_warp_fetch
//
// Directed bench for gelato_multi_warp_fetch with default parameters
// (8 warps, 32-bit PCs, 2-instruction bundles, 4 ibuffer credits per warp).
// Inputs change 1 ns after the rising edge. Outputs are sampled at the same
// point, after the registers have settled.
// ---------------------------------------------------------------------------
module tb_gelato_multi_warp_fetch;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        init_valid;
  logic [2:0]  init_warp_id;
  logic [31:0] init_pc;
  logic        redirect_valid;
  logic [2:0]  redirect_warp_id;
  logic [31:0] redirect_pc;
  logic        finish_valid;
  logic [2:0]  finish_warp_id;
  logic        credit_valid;
  logic [2:0]  credit_warp_id;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic [63:0] resp_data;
  logic        out_valid;
  logic [2:0]  out_warp_id;
  logic [31:0] out_pc;
  logic [63:0] out_data;
  logic [1:0]  out_mask;
  logic [7:0]  active_mask;

  int compared;
  int mismatched;

  logic [2:0]  rrWarp [3] = '{3'd0, 3'd2, 3'd5};
  logic [31:0] rrBase [3] = '{32'h100, 32'h200, 32'h500};

  gelato_multi_warp_fetch dut (
    .clk              (clk),
    .rst              (rst),
    .rdy              (rdy),
    .init_valid       (init_valid),
    .init_warp_id     (init_warp_id),
    .init_pc          (init_pc),
    .redirect_valid   (redirect_valid),
    .redirect_warp_id (redirect_warp_id),
    .redirect_pc      (redirect_pc),
    .finish_valid     (finish_valid),
    .finish_warp_id   (finish_warp_id),
    .credit_valid     (credit_valid),
    .credit_warp_id   (credit_warp_id),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_addr         (req_addr),
    .resp_valid       (resp_valid),
    .resp_data        (resp_data),
    .out_valid        (out_valid),
    .out_warp_id      (out_warp_id),
    .out_pc           (out_pc),
    .out_data         (out_data),
    .out_mask         (out_mask),
    .active_mask      (active_mask)
  );

  // 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the design never releases a handshake.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at 200 us, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every comparison in the bench funnels through here.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] bundleFor(input logic [31:0] addr);
    return {addr ^ 32'hCAFE_F00D, addr ^ 32'h1234_5678};
  endfunction

  // Pulse any mix of events on one warp for one cycle.
  task automatic applyStimulus(input logic doInit, input logic doRedir, input logic doFin,
                               input logic doCred, input logic [2:0] w, input logic [31:0] pc);
    init_valid       = doInit;
    init_warp_id     = w;
    init_pc          = pc;
    redirect_valid   = doRedir;
    redirect_warp_id = w;
    redirect_pc      = pc;
    finish_valid     = doFin;
    finish_warp_id   = w;
    credit_valid     = doCred;
    credit_warp_id   = w;
    tick();
    init_valid     = 1'b0;
    redirect_valid = 1'b0;
    finish_valid   = 1'b0;
    credit_valid   = 1'b0;
  endtask

  // Bounded wait for a request. An expired bound shows up as a failed check.
  task automatic waitReq(input string tag);
    int n = 0;
    while (!req_valid && n < 20) begin
      tick();
      n++;
    end
    checkOutput({tag, " req_valid"}, {63'd0, req_valid}, 64'd1);
  endtask

  task automatic checkIdle(input string tag, input int cycles);
    for (int k = 0; k < cycles; k++) begin
      tick();
      checkOutput({tag, " no req"}, {63'd0, req_valid}, 64'd0);
    end
  endtask

  // Serve one request with immediate ready and response, then check the
  // bundle that comes out.
  task automatic fetchOne(input string tag, input logic [2:0] expWarp,
                          input logic [31:0] expAddr, input logic [1:0] expMask);
    waitReq(tag);
    checkOutput({tag, " req_addr"}, {32'd0, req_addr}, {32'd0, expAddr});
    req_ready = 1'b1;
    tick();
    req_ready  = 1'b0;
    resp_valid = 1'b1;
    resp_data  = bundleFor(expAddr);
    tick();
    resp_valid = 1'b0;
    checkOutput({tag, " out_valid"}, {63'd0, out_valid}, 64'd1);
    checkOutput({tag, " out_warp_id"}, {61'd0, out_warp_id}, {61'd0, expWarp});
    checkOutput({tag, " out_pc"}, {32'd0, out_pc}, {32'd0, expAddr});
    checkOutput({tag, " out_mask"}, {62'd0, out_mask}, {62'd0, expMask});
    checkOutput({tag, " out_data"}, out_data, bundleFor(expAddr));
    tick();
    checkOutput({tag, " out_valid pulse"}, {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    compared         = 0;
    mismatched       = 0;
    rst              = 1'b1;
    rdy              = 1'b1;
    init_valid       = 1'b0;
    init_warp_id     = '0;
    init_pc          = '0;
    redirect_valid   = 1'b0;
    redirect_warp_id = '0;
    redirect_pc      = '0;
    finish_valid     = 1'b0;
    finish_warp_id   = '0;
    credit_valid     = 1'b0;
    credit_warp_id   = '0;
    req_ready        = 1'b0;
    resp_valid       = 1'b0;
    resp_data        = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    checkOutput("reset req_valid", {63'd0, req_valid}, 64'd0);
    checkOutput("reset out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("reset active_mask", {56'd0, active_mask}, 64'd0);
    checkOutput("reset req_addr", {32'd0, req_addr}, 64'd0);

    // Warp 3 starts mid-bundle, then runs out of its 4 credits.
    $display("[TB] warp 3 alignment and credit exhaustion");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 32'h1004);
    checkOutput("init3 active_mask", {56'd0, active_mask}, 64'h08);
    fetchOne("w3 b0", 3'd3, 32'h1000, 2'b10);
    fetchOne("w3 b1", 3'd3, 32'h1008, 2'b11);
    fetchOne("w3 b2", 3'd3, 32'h1010, 2'b11);
    fetchOne("w3 b3", 3'd3, 32'h1018, 2'b11);
    checkIdle("w3 exhausted", 5);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 32'h0);
    fetchOne("w3 credit", 3'd3, 32'h1020, 2'b11);
    checkIdle("w3 after credit", 4);

    // Round-robin among warps 0, 2 and 5, draining all their credits.
    $display("[TB] round-robin warps 0/2/5");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'h100);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 32'h200);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'd5, 32'h500);
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 3; j++) begin
        fetchOne("rr", rrWarp[j], rrBase[j] + 32'(8 * r), 2'b11);
      end
    end
    checkIdle("rr drained", 3);

    // Redirect while waiting squashes the response and refunds the credit.
    $display("[TB] redirect warp 1 during WAIT");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 32'h40);
    waitReq("w1 first");
    checkOutput("w1 first req_addr", {32'd0, req_addr}, 64'h40);
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 32'h2000);
    resp_valid = 1'b1;
    resp_data  = bundleFor(32'h40);
    tick();
    resp_valid = 1'b0;
    checkOutput("w1 squash out_valid", {63'd0, out_valid}, 64'd0);
    fetchOne("w1 r0", 3'd1, 32'h2000, 2'b11);
    fetchOne("w1 r1", 3'd1, 32'h2008, 2'b11);
    fetchOne("w1 r2", 3'd1, 32'h2010, 2'b11);
    fetchOne("w1 r3", 3'd1, 32'h2018, 2'b11);
    checkIdle("w1 credits net", 3);

    // Redirect in the same cycle as the response: redirect wins.
    $display("[TB] redirect coincident with response");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 32'h0);
    waitReq("w1 coincide");
    checkOutput("w1 coincide req_addr", {32'd0, req_addr}, 64'h2020);
    req_ready = 1'b1;
    tick();
    req_ready        = 1'b0;
    resp_valid       = 1'b1;
    resp_data        = bundleFor(32'h2020);
    redirect_valid   = 1'b1;
    redirect_warp_id = 3'd1;
    redirect_pc      = 32'h3000;
    tick();
    resp_valid     = 1'b0;
    redirect_valid = 1'b0;
    checkOutput("w1 coincide out_valid", {63'd0, out_valid}, 64'd0);
    fetchOne("w1 after coincide", 3'd1, 32'h3000, 2'b11);

    // Stalled request stays stable, and finish during the stall drops it.
    $display("[TB] stalled request with finish");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'd6, 32'h600);
    waitReq("w6");
    checkOutput("w6 active_mask", {56'd0, active_mask}, 64'h6F);
    for (int k = 0; k < 5; k++) begin
      if (k == 2) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 3'd6, 32'h0);
      else tick();
      checkOutput("w6 stall req_valid", {63'd0, req_valid}, 64'd1);
      checkOutput("w6 stall req_addr", {32'd0, req_addr}, 64'h600);
    end
    checkOutput("w6 finished active_mask", {56'd0, active_mask}, 64'h2F);
    req_ready = 1'b1;
    tick();
    req_ready  = 1'b0;
    resp_valid = 1'b1;
    resp_data  = bundleFor(32'h600);
    tick();
    resp_valid = 1'b0;
    checkOutput("w6 dropped out_valid", {63'd0, out_valid}, 64'd0);
    checkIdle("w6 gone", 2);

    // rdy low freezes the handshake. Then reset during WAIT plus a stray response.
    $display("[TB] rdy freeze and reset during WAIT");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 32'h0);
    waitReq("w1 rst");
    checkOutput("w1 rst req_addr", {32'd0, req_addr}, 64'h3008);
    rdy       = 1'b0;
    req_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("frozen req_valid", {63'd0, req_valid}, 64'd1);
    end
    rdy = 1'b1;
    tick();
    req_ready = 1'b0;
    checkOutput("accepted req_valid", {63'd0, req_valid}, 64'd0);
    rst = 1'b1;
    tick();
    rst        = 1'b0;
    resp_valid = 1'b1;
    resp_data  = bundleFor(32'h3008);
    tick();
    resp_valid = 1'b0;
    checkOutput("stray out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("post-reset active_mask", {56'd0, active_mask}, 64'd0);
    checkOutput("post-reset req_valid", {63'd0, req_valid}, 64'd0);
    tick();
    checkOutput("stray out_valid later", {63'd0, out_valid}, 64'd0);

    // Init and finish together: finish wins. Then PC wrap at the top of memory.
    $display("[TB] init+finish and PC wrap");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 3'd7, 32'hFFFF_FFFC);
    checkOutput("init+finish active_mask", {56'd0, active_mask}, 64'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'd7, 32'hFFFF_FFFC);
    checkOutput("w7 active_mask", {56'd0, active_mask}, 64'h80);
    fetchOne("w7 top", 3'd7, 32'hFFFF_FFF8, 2'b10);
    fetchOne("w7 wrap", 3'd7, 32'h0000_0000, 2'b11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/gelato_multi_warp_fetch.md
Name: gelato_multi_warp_fetch

Overview:
Parametrised successor to the single-path Gelato fetch stage. Holds a per-warp PC table and picks among NUM_WARPS warps round-robin. For the chosen warp it issues one aligned FETCH_WIDTH-instruction bundle request to the L1 instruction cache and forwards the returned bundle, with a slot-valid mask, to decode/ibuffer. Adds three things the previous stage lacks:
- per-warp ibuffer credit flow control
- PC redirect with stale-response squashing
- warp finish handling

Parameters:
NUM_WARPS, 8, number of warps tracked; WARP_ID_W = $clog2(NUM_WARPS)
PC_WIDTH, 32, PC/byte-address width
INST_WIDTH, 32, bits per instruction (4-byte instructions)
FETCH_WIDTH, 2, instructions per bundle; power of 2, ≥1; SLOT_W = $clog2(FETCH_WIDTH)
IBUF_DEPTH, 4, ibuffer bundle slots per warp = initial/max credits

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
rdy  in  1  global enable; 0 freezes every register
init_valid  in  1  start warp
init_warp_id  in  WARP_ID_W  warp to start
init_pc  in  PC_WIDTH  start PC
redirect_valid  in  1  PC change (branch/split table)
redirect_warp_id  in  WARP_ID_W  target warp
redirect_pc  in  PC_WIDTH  new PC
finish_valid  in  1  warp exited
finish_warp_id  in  WARP_ID_W  exiting warp
credit_valid  in  1  ibuffer freed one bundle slot
credit_warp_id  in  WARP_ID_W  owner of freed slot
req_valid  out  1  cache request
req_ready  in  1  cache accepts request
req_addr  out  PC_WIDTH  bundle-aligned address
resp_valid  in  1  cache data return, in order, one per accepted request
resp_data  in  FETCH_WIDTH*INST_WIDTH  bundle, slot 0 in LSBs
out_valid  out  1  bundle to decode
out_warp_id  out  WARP_ID_W  bundle owner
out_pc  out  PC_WIDTH  aligned bundle address
out_data  out  FETCH_WIDTH*INST_WIDTH  bundle
out_mask  out  FETCH_WIDTH  valid slots
active_mask  out  NUM_WARPS  warps currently active

Behaviour:
Reset and enable:
- Reset clears every active bit, sets all credits to IBUF_DEPTH, and zeroes all PCs, the RR pointer and the stale flag.
- Reset puts the FSM in IDLE and drives all outputs to 0.
- Reset mid-transaction abandons the outstanding request. A resp_valid arriving with nothing outstanding (state ≠ WAIT) is ignored.
- rdy=0: no state changes. Upstream must not pulse events while rdy=0; such events are lost.

Per-warp state: active, pc, credits (0..IBUF_DEPTH), stale.

Event updates (all take effect at the clock edge):
- init on an inactive warp: active=1, pc=init_pc, credits=IBUF_DEPTH. init on an active warp is ignored.
- redirect on an active warp: pc=redirect_pc. If that warp is the one in flight (REQ or WAIT), set stale. redirect on an inactive warp is ignored.
- finish: active=0. If that warp is in flight, set stale.
- credit: credits+1, saturating at IBUF_DEPTH.

Eligibility: active && credits>0 && not the in-flight warp.

FSM:
- IDLE: pick the first eligible warp starting at rr_ptr+1 modulo NUM_WARPS. If one is found, latch warp id and req_addr = pc with the low SLOT_W+2 bits cleared, decrement its credits, set rr_ptr = that id, and go to REQ. req_valid rises the cycle after the warp becomes eligible.
- REQ: req_valid=1 with req_addr stable. On req_ready, go to WAIT. A redirect or finish in REQ does not withdraw the request; it only sets stale.
- WAIT: on resp_valid, go to IDLE the next cycle.
  - Not stale: register out_valid=1 for exactly one cycle (the cycle after resp_valid), with out_data=resp_data, out_pc=req_addr, and out_mask bit i = (i ≥ pc[SLOT_W+1:2]) using the PC latched at pick. Set pc = req_addr + FETCH_WIDTH*4, wrapping modulo 2^PC_WIDTH.
  - Stale: no output, credit restored (+1), pc not advanced, stale cleared.

Simultaneous events:
- Redirect and resp_valid for the same warp in the same cycle: the redirect wins and the response is squashed.
- Credit return and credit consume for the same warp in the same cycle: net 0.
- init and finish for the same warp in the same cycle: finish wins.
- Independent events on different warps all apply in the same cycle.

Other rules:
- out has no backpressure; credits guarantee ibuffer space.
- One request outstanding at a time.
- active_mask is a direct copy of the active bits.

Test Plan:
- Reset, then init warp 3 pc=0x1004 (FETCH_WIDTH=2) → req_addr=0x1000; after resp, out_pc=0x1000 and out_mask=2'b10; next req_addr=0x1008 with out_mask=2'b11.
- Init warps 0, 2, 5, all with credits, immediate req_ready/resp → grant order 0, 2, 5, 0, … round-robin.
- IBUF_DEPTH=4, single warp, no credit returns → exactly 4 bundles, then req_valid stays 0. One credit_valid → exactly one more request.
- Redirect warp 1 to 0x2000 while in WAIT → resp squashed (out_valid stays 0), credits unchanged net, next req_addr=0x2000.
- Hold req_ready=0 for 5 cycles → req_valid and req_addr stable throughout. Finish the warp meanwhile → its response is dropped and active_mask bit cleared.
- Assert rst during WAIT, then a stray resp_valid → no out_valid, active_mask=0, req_valid=0.
